branch_resolve_unit: RTL and testbench

- Parametrised successor to the dual-issue branch controller. Resolves BEQ, JAL and JLR for an ISSUE_W-wide bundle in the ID/RF stage.
- Picks the oldest taken control-transfer, kills all younger slots and computes the target PC and link values.
- Issues a registered one-cycle redirect to fetch, then squashes the wrong-path bundles already in flight using a squash counter.

---
 rtl/bru_pkg.sv | 12 +
 rtl/bru_slot_eval.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared constants for the branch resolve unit: opcode encodings, slot field
// widths and squash counter width.
package bru_pkg;

   localparam int OPC_W    = 4;
   localparam int SQUASH_W = 4;

   localparam logic [OPC_W-1:0] OP_BEQ = 4'b1100;
   localparam logic [OPC_W-1:0] OP_JAL = 4'b1000;
   localparam logic [OPC_W-1:0] OP_JLR = 4'b1001;

endpackage

// File: rtl/bru_slot_eval.sv
// Per-slot branch evaluation: taken decision, target PC and link value.
// The is_beq output only exists when BRU_PERF_CNT_EN is defined.
module bru_slot_eval
   import bru_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              valid,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] ra,
   input  logic [DATA_W-1:0] rb,
   output logic              is_taken,
   output logic [DATA_W-1:0] target,
   output logic [DATA_W-1:0] link
`ifdef BRU_PERF_CNT_EN
   ,
   output logic              is_beq
`endif
);

   // Target and link wrap modulo 2^DATA_W.
   always_comb begin
      is_taken = 1'b0;
      target   = pc + imm;
      case (opcode)
         OP_BEQ:  is_taken = valid & (ra == rb);
         OP_JAL:  is_taken = valid;
         OP_JLR: begin
            is_taken = valid;
            target   = rb;
         end
         default: is_taken = 1'b0;
      endcase
   end

   assign link = pc + DATA_W'(1);

`ifdef BRU_PERF_CNT_EN
   assign is_beq = (opcode == OP_BEQ);
`endif

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BEQ/JAL/JLR across an ISSUE_W-wide bundle, issues a registered
// redirect and squashes wrong-path bundles. BRU_PERF_CNT_EN adds perf counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int ISSUE_W       = 2,
   parameter int DATA_W        = 16,
   parameter int SQUASH_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        stall_in,
   input  logic [ISSUE_W-1:0]          valid_in,
   input  logic [OPC_W*ISSUE_W-1:0]    opcode_in,
   input  logic [DATA_W*ISSUE_W-1:0]   pc_in,
   input  logic [DATA_W*ISSUE_W-1:0]   imm_in,
   input  logic [DATA_W*ISSUE_W-1:0]   ra_in,
   input  logic [DATA_W*ISSUE_W-1:0]   rb_in,
   output logic [ISSUE_W-1:0]          valid_out,
   output logic [DATA_W*ISSUE_W-1:0]   link_out,
   output logic                        redirect_valid,
   output logic [DATA_W-1:0]           redirect_pc,
   output logic                        squash_active
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]            taken_cnt,
   output logic [CNT_W-1:0]            nottaken_cnt
`endif
);

   logic [ISSUE_W-1:0][DATA_W-1:0] tgt;
   logic [ISSUE_W-1:0]             taken;
   logic [ISSUE_W-1:0]             keep;
   logic [DATA_W-1:0]              sel_target;
   logic                           any_taken;
   logic                           capture;
   logic [SQUASH_W-1:0]            squash_cnt;

`ifdef BRU_PERF_CNT_EN
   logic [ISSUE_W-1:0]             is_beq;
`endif

   for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
      bru_slot_eval #(.DATA_W(DATA_W)) u_slot (
         .valid    (valid_in[g]),
         .opcode   (opcode_in[OPC_W*g +: OPC_W]),
         .pc       (pc_in[DATA_W*g +: DATA_W]),
         .imm      (imm_in[DATA_W*g +: DATA_W]),
         .ra       (ra_in[DATA_W*g +: DATA_W]),
         .rb       (rb_in[DATA_W*g +: DATA_W]),
         .is_taken (taken[g]),
         .target   (tgt[g]),
         .link     (link_out[DATA_W*g +: DATA_W])
`ifdef BRU_PERF_CNT_EN
         ,
         .is_beq   (is_beq[g])
`endif
      );
   end

   // Oldest taken slot wins; every slot younger than it is dropped.
   always_comb begin
      any_taken  = 1'b0;
      sel_target = '0;
      keep       = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         keep[i] = ~any_taken;
         if (taken[i] && !any_taken) begin
            any_taken  = 1'b1;
            sel_target = tgt[i];
         end
      end
   end

   assign squash_active = (squash_cnt != '0);
   assign valid_out     = valid_in & keep & {ISSUE_W{~squash_active}};
   assign capture       = ~stall_in & ~squash_active & any_taken;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         squash_cnt     <= '0;
      end else if (stall_in) begin
         redirect_valid <= 1'b0;
      end else begin
         redirect_valid <= capture;
         if (capture) begin
            redirect_pc <= sel_target;
            squash_cnt  <= SQUASH_W'(SQUASH_CYCLES);
         end else if (squash_active) begin
            squash_cnt  <= squash_cnt - SQUASH_W'(1);
         end
      end
   end

`ifdef BRU_PERF_CNT_EN
   localparam int NT_W  = $clog2(ISSUE_W + 1);
   localparam int SUM_W = CNT_W + NT_W;

   logic [NT_W-1:0]  nt_count;
   logic [SUM_W-1:0] nt_sum;
   logic [CNT_W-1:0] nt_next;

   // Surviving BEQs that fell through; valid_out already folds in squash/kill.
   always_comb begin
      nt_count = '0;
      for (int i = 0; i < ISSUE_W; i++)
         if (valid_out[i] && is_beq[i] && !taken[i])
            nt_count = nt_count + NT_W'(1);
   end

   assign nt_sum  = SUM_W'(nottaken_cnt) + SUM_W'(nt_count);
   assign nt_next = (nt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : nt_sum[CNT_W-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         taken_cnt    <= '0;
         nottaken_cnt <= '0;
      end else if (!stall_in && !squash_active) begin
         if (capture && (taken_cnt != {CNT_W{1'b1}}))
            taken_cnt <= taken_cnt + CNT_W'(1);
         nottaken_cnt <= nt_next;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: instance a uses defaults, instance b
// uses SQUASH_CYCLES=3 and CNT_W=2 (counters checked when BRU_PERF_CNT_EN is set).
module tb_branch_resolve_unit;

   localparam int IW = 2;
   localparam int DW = 16;

   localparam logic [3:0] BEQ = 4'b1100;
   localparam logic [3:0] JAL = 4'b1000;
   localparam logic [3:0] JLR = 4'b1001;
   localparam logic [3:0] ADD = 4'b0000;

   logic             clock, reset, stall_in;
   logic [IW-1:0]    valid_in;
   logic [4*IW-1:0]  opcode_in;
   logic [DW*IW-1:0] pc_in, imm_in, ra_in, rb_in;

   logic [IW-1:0]    valid_out_a, valid_out_b;
   logic [DW*IW-1:0] link_out_a, link_out_b;
   logic             redirect_valid_a, redirect_valid_b;
   logic [DW-1:0]    redirect_pc_a, redirect_pc_b;
   logic             squash_active_a, squash_active_b;
`ifdef BRU_PERF_CNT_EN
   logic [15:0]      taken_cnt_a, nottaken_cnt_a;
   logic [1:0]       taken_cnt_b, nottaken_cnt_b;
`endif

   int n_cmp = 0;
   int n_err = 0;

   branch_resolve_unit u_dut_a (
      .clock(clock), .reset(reset), .stall_in(stall_in), .valid_in(valid_in),
      .opcode_in(opcode_in), .pc_in(pc_in), .imm_in(imm_in), .ra_in(ra_in), .rb_in(rb_in),
      .valid_out(valid_out_a), .link_out(link_out_a), .redirect_valid(redirect_valid_a),
      .redirect_pc(redirect_pc_a), .squash_active(squash_active_a)
`ifdef BRU_PERF_CNT_EN
      , .taken_cnt(taken_cnt_a), .nottaken_cnt(nottaken_cnt_a)
`endif
   );

   branch_resolve_unit #(.SQUASH_CYCLES(3), .CNT_W(2)) u_dut_b (
      .clock(clock), .reset(reset), .stall_in(stall_in), .valid_in(valid_in),
      .opcode_in(opcode_in), .pc_in(pc_in), .imm_in(imm_in), .ra_in(ra_in), .rb_in(rb_in),
      .valid_out(valid_out_b), .link_out(link_out_b), .redirect_valid(redirect_valid_b),
      .redirect_pc(redirect_pc_b), .squash_active(squash_active_b)
`ifdef BRU_PERF_CNT_EN
      , .taken_cnt(taken_cnt_b), .nottaken_cnt(nottaken_cnt_b)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_bundle();
      valid_in  = '0;
      opcode_in = '0;
      pc_in     = '0;
      imm_in    = '0;
      ra_in     = '0;
      rb_in     = '0;
   endtask

   task automatic set_slot(input int i, input logic v, input logic [3:0] op,
                           input logic [15:0] pc, input logic [15:0] imm,
                           input logic [15:0] ra, input logic [15:0] rb);
      valid_in[i]        = v;
      opcode_in[4*i +: 4] = op;
      pc_in[DW*i +: DW]  = pc;
      imm_in[DW*i +: DW] = imm;
      ra_in[DW*i +: DW]  = ra;
      rb_in[DW*i +: DW]  = rb;
   endtask

   task automatic idle(input int n);
      clear_bundle();
      stall_in = 1'b0;
      repeat (n) step();
   endtask

   task automatic test_reset();
      n_cmp++; if (redirect_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_rv: got %b want 0", redirect_valid_a); end
      n_cmp++; if (redirect_pc_a !== 16'h0000) begin n_err++; $display("FAIL rst_pc: got %h want 0000", redirect_pc_a); end
      n_cmp++; if (squash_active_a !== 1'b0) begin n_err++; $display("FAIL rst_sq: got %b want 0", squash_active_a); end
      n_cmp++; if (valid_out_a !== 2'b00) begin n_err++; $display("FAIL rst_vo: got %b want 00", valid_out_a); end
   endtask

   task automatic test_beq_taken();
      clear_bundle();
      set_slot(0, 1'b1, BEQ, 16'h0010, 16'h0004, 16'd5, 16'd5);
      set_slot(1, 1'b1, ADD, 16'h0011, 16'h0000, 16'd0, 16'd0);
      #1;
      n_cmp++; if (valid_out_a !== 2'b01) begin n_err++; $display("FAIL beq_vo: got %b want 01", valid_out_a); end
      step();
      n_cmp++; if (redirect_valid_a !== 1'b1) begin n_err++; $display("FAIL beq_rv: got %b want 1", redirect_valid_a); end
      n_cmp++; if (redirect_pc_a !== 16'h0014) begin n_err++; $display("FAIL beq_pc: got %h want 0014", redirect_pc_a); end
      set_slot(0, 1'b1, ADD, 16'h0012, 16'h0000, 16'd0, 16'd0);
      set_slot(1, 1'b1, ADD, 16'h0013, 16'h0000, 16'd0, 16'd0);
      #1;
      n_cmp++; if (valid_out_a !== 2'b00) begin n_err++; $display("FAIL beq_squash_vo: got %b want 00", valid_out_a); end
      step();
      n_cmp++; if (redirect_valid_a !== 1'b0) begin n_err++; $display("FAIL beq_rv_pulse: got %b want 0", redirect_valid_a); end
      n_cmp++; if (squash_active_a !== 1'b0) begin n_err++; $display("FAIL beq_sq_end: got %b want 0", squash_active_a); end
   endtask

   task automatic test_jlr();
      clear_bundle();
      set_slot(0, 1'b1, ADD, 16'h0020, 16'h0000, 16'd0, 16'd0);
      set_slot(1, 1'b1, JLR, 16'h0021, 16'h0000, 16'd0, 16'h0200);
      #1;
      n_cmp++; if (valid_out_a !== 2'b11) begin n_err++; $display("FAIL jlr_vo: got %b want 11", valid_out_a); end
      n_cmp++; if (link_out_a[31:16] !== 16'h0022) begin n_err++; $display("FAIL jlr_link: got %h want 0022", link_out_a[31:16]); end
      step();
      n_cmp++; if (redirect_pc_a !== 16'h0200) begin n_err++; $display("FAIL jlr_pc: got %h want 0200", redirect_pc_a); end
      n_cmp++; if (squash_active_a !== 1'b1) begin n_err++; $display("FAIL jlr_sq_on: got %b want 1", squash_active_a); end
      clear_bundle();
      step();
      n_cmp++; if (squash_active_a !== 1'b0) begin n_err++; $display("FAIL jlr_sq_off: got %b want 0", squash_active_a); end
   endtask

   task automatic test_jal_wrap();
      clear_bundle();
      set_slot(0, 1'b1, BEQ, 16'h00FE, 16'h0005, 16'd1, 16'd2);
      set_slot(1, 1'b1, JAL, 16'h00FF, 16'hFF02, 16'd0, 16'd0);
      #1;
      n_cmp++; if (valid_out_a !== 2'b11) begin n_err++; $display("FAIL wrap_vo: got %b want 11", valid_out_a); end
      step();
      n_cmp++; if (redirect_valid_a !== 1'b1) begin n_err++; $display("FAIL wrap_rv: got %b want 1", redirect_valid_a); end
      n_cmp++; if (redirect_pc_a !== 16'h0001) begin n_err++; $display("FAIL wrap_pc: got %h want 0001", redirect_pc_a); end
   endtask

   task automatic test_invalid_slot();
      // Invalid JAL in slot 0 must not win; slot 1 BEQ resolves instead.
      clear_bundle();
      set_slot(0, 1'b0, JAL, 16'h0030, 16'h0100, 16'd0, 16'd0);
      set_slot(1, 1'b1, BEQ, 16'h0031, 16'hFFFF, 16'd7, 16'd7);
      #1;
      n_cmp++; if (valid_out_a !== 2'b10) begin n_err++; $display("FAIL inv_vo: got %b want 10", valid_out_a); end
      step();
      n_cmp++; if (redirect_pc_a !== 16'h0030) begin n_err++; $display("FAIL inv_pc: got %h want 0030", redirect_pc_a); end
      clear_bundle();
      step();
      #1;
      n_cmp++; if (valid_out_a !== 2'b00) begin n_err++; $display("FAIL idle_vo: got %b want 00", valid_out_a); end
      step();
      n_cmp++; if (redirect_valid_a !== 1'b0) begin n_err++; $display("FAIL idle_rv: got %b want 0", redirect_valid_a); end
   endtask

   task automatic test_stall();
      clear_bundle();
      stall_in = 1'b1;
      set_slot(0, 1'b1, JAL, 16'h0040, 16'h0010, 16'd0, 16'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++; if (redirect_valid_a !== 1'b0) begin n_err++; $display("FAIL stall_rv%0d: got %b want 0", c, redirect_valid_a); end
      end
      stall_in = 1'b0;
      step();
      n_cmp++; if (redirect_valid_a !== 1'b1) begin n_err++; $display("FAIL stall_release_rv: got %b want 1", redirect_valid_a); end
      n_cmp++; if (redirect_pc_a !== 16'h0050) begin n_err++; $display("FAIL stall_release_pc: got %h want 0050", redirect_pc_a); end
      clear_bundle();
      step();
      n_cmp++; if (redirect_valid_a !== 1'b0) begin n_err++; $display("FAIL stall_single_pulse: got %b want 0", redirect_valid_a); end
      // Counter must hold while stalled mid-squash.
      set_slot(0, 1'b1, JAL, 16'h0060, 16'h0001, 16'd0, 16'd0);
      step();
      clear_bundle();
      stall_in = 1'b1;
      step();
      step();
      n_cmp++; if (squash_active_a !== 1'b1) begin n_err++; $display("FAIL stall_sq_hold: got %b want 1", squash_active_a); end
      stall_in = 1'b0;
      step();
      n_cmp++; if (squash_active_a !== 1'b0) begin n_err++; $display("FAIL stall_sq_release: got %b want 0", squash_active_a); end
   endtask

   task automatic test_squash3();
      clear_bundle();
      set_slot(0, 1'b1, JAL, 16'h0100, 16'h0008, 16'd0, 16'd0);
      step();
      n_cmp++; if (redirect_pc_b !== 16'h0108) begin n_err++; $display("FAIL sq3_pc: got %h want 0108", redirect_pc_b); end
      for (int c = 0; c < 3; c++) begin
         clear_bundle();
         set_slot(0, 1'b1, BEQ, 16'h0200, 16'h0001, 16'd9, 16'd9);
         set_slot(1, 1'b1, ADD, 16'h0201, 16'h0000, 16'd0, 16'd0);
         #1;
         n_cmp++; if (valid_out_b !== 2'b00) begin n_err++; $display("FAIL sq3_vo%0d: got %b want 00", c, valid_out_b); end
         step();
         n_cmp++; if (redirect_valid_b !== 1'b0) begin n_err++; $display("FAIL sq3_rv%0d: got %b want 0", c, redirect_valid_b); end
      end
      n_cmp++; if (squash_active_b !== 1'b0) begin n_err++; $display("FAIL sq3_end: got %b want 0", squash_active_b); end
      // Asynchronous reset mid-squash, away from any clock edge.
      clear_bundle();
      set_slot(0, 1'b1, JAL, 16'h0300, 16'h0004, 16'd0, 16'd0);
      step();
      clear_bundle();
      #3;
      reset = 1'b0;
      #1;
      n_cmp++; if (squash_active_b !== 1'b0) begin n_err++; $display("FAIL arst_sq: got %b want 0", squash_active_b); end
      n_cmp++; if (redirect_valid_b !== 1'b0) begin n_err++; $display("FAIL arst_rv: got %b want 0", redirect_valid_b); end
      n_cmp++; if (redirect_pc_b !== 16'h0000) begin n_err++; $display("FAIL arst_pc: got %h want 0000", redirect_pc_b); end
      #2;
      reset = 1'b1;
      step();
   endtask

`ifdef BRU_PERF_CNT_EN
   task automatic test_perf();
      for (int r = 0; r < 5; r++) begin
         clear_bundle();
         set_slot(0, 1'b1, JAL, 16'h0400, 16'h0002, 16'd0, 16'd0);
         step();
         idle(3);
         if (r == 1) begin
            n_cmp++; if (taken_cnt_b !== 2'd2) begin n_err++; $display("FAIL perf_taken2: got %0d want 2", taken_cnt_b); end
         end
      end
      n_cmp++; if (taken_cnt_b !== 2'd3) begin n_err++; $display("FAIL perf_taken_sat: got %0d want 3", taken_cnt_b); end
      clear_bundle();
      set_slot(0, 1'b1, BEQ, 16'h0500, 16'h0002, 16'd1, 16'd2);
      set_slot(1, 1'b1, BEQ, 16'h0501, 16'h0002, 16'd3, 16'd4);
      step();
      n_cmp++; if (nottaken_cnt_b !== 2'd2) begin n_err++; $display("FAIL perf_nt2: got %0d want 2", nottaken_cnt_b); end
      step();
      n_cmp++; if (nottaken_cnt_b !== 2'd3) begin n_err++; $display("FAIL perf_nt_sat: got %0d want 3", nottaken_cnt_b); end
   endtask
`endif

   initial begin
      reset    = 1'b0;
      stall_in = 1'b0;
      clear_bundle();
      step();
      step();
      test_reset();
      reset = 1'b1;
      step();
      test_beq_taken();
      idle(4);
      test_jlr();
      idle(4);
      test_jal_wrap();
      idle(4);
      test_invalid_slot();
      idle(4);
      test_stall();
      idle(4);
      test_squash3();
      idle(4);
`ifdef BRU_PERF_CNT_EN
      test_perf();
      idle(4);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
